apb_protocol_checker: RTL

Synthesizable, parametrised APB4 protocol checker that passively monitors one APB requester port with up to NUM_SEL completers. It tracks the IDLE/SETUP/ACCESS state machine, checks signal stability across wait states, bounds wait states with a timeout, and reports violations through sticky flags, a one-cycle pulse, and first-error capture. It sits beside the APB bridge in both simulation and emulation builds and gives a hardware-visible successor to simulation-only property checks.

---
 rtl/apb_protocol_checker.sv | 299 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/apb_protocol_checker.sv
// ---------------------------------------------------------------------------
// apb_protocol_checker
//
// Passive APB4 protocol monitor for one requester port that drives up to
// NUM_SEL completers. It follows the IDLE/SETUP/ACCESS phases seen on the
// bus, checks that request signals stay stable through wait states, limits
// the number of wait states, and reports each violation three ways: as a
// sticky flag, as a one-cycle pulse, and as a capture of the first error.
// It also counts completed transfers and completed transfers with PSLVERR.
//
// Parameters
//   ADDR_WIDTH  PADDR width
//   DATA_WIDTH  PWDATA/PRDATA width (8, 16 or 32); PSTRB is DATA_WIDTH/8
//   NUM_SEL     number of PSEL lines (1..16)
//   TIMEOUT     maximum ACCESS wait cycles with PREADY low (1..255)
//   CNT_WIDTH   width of the completed-transfer counter
//
// Ports
//   PCLK, PRESETn        clock, asynchronous active-low reset
//   PSEL .. PSLVERR      monitored APB signals (inputs only)
//   err_clr              synchronous clear of sticky flags and first-error
//                        capture; the transfer counters are not affected
//   err_sticky[5:0]      per-class sticky flags (bit index = class code)
//   err_pulse            high for one cycle after any violation is seen
//   err_first_code       class of the first violation since reset/clear
//   err_first_addr       PADDR sampled together with that first violation
//   txn_cnt              completed transfers, saturating
//   slverr_cnt           completed transfers with PSLVERR, saturating
//
// Violation classes
//   0 SEL_MULTI  more than one PSEL bit set
//   1 NO_SETUP   ACCESS without a preceding SETUP or ACCESS wait cycle
//   2 NO_ACCESS  SETUP followed by something other than ACCESS
//   3 UNSTABLE   request signals changed during ACCESS
//   4 TIMEOUT    wait-state count reached TIMEOUT (once per transfer)
//   5 STRB_READ  PSTRB nonzero during a read
//
// Build option
//   APB_CHK_STRB_EN  when defined, PSTRB is part of the stability check and
//                    class 5 is active. When undefined, PSTRB is ignored,
//                    err_sticky[5] is constant 0 and there is no PSTRB
//                    capture register.
//
// FSM states
//   state     | meaning
//   ST_IDLE   | no transfer open: idle bus, or the last ACCESS completed
//   ST_SETUP  | the previous cycle was a SETUP cycle
//   ST_ACCESS | the previous cycle was an ACCESS wait cycle (PREADY low)
// ---------------------------------------------------------------------------
module apb_protocol_checker #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SEL    = 1,
    parameter int TIMEOUT    = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic [NUM_SEL-1:0]      PSEL,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH-1:0]   PRDATA,
    input  logic [2:0]              PPROT,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    input  logic                    PWRITE,
    input  logic                    PENABLE,
    input  logic                    PREADY,
    input  logic                    PSLVERR,
    input  logic                    err_clr,
    output logic [5:0]              err_sticky,
    output logic                    err_pulse,
    output logic [2:0]              err_first_code,
    output logic [ADDR_WIDTH-1:0]   err_first_addr,
    output logic [CNT_WIDTH-1:0]    txn_cnt,
    output logic [7:0]              slverr_cnt
);

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Bus phase decoded from the sampled inputs
    logic sel_any;
    logic bus_setup;
    logic bus_access;
    logic bus_done;
    logic bus_wait;
    logic preceded;
    logic capture;

    assign sel_any    = |PSEL;
    assign bus_setup  = sel_any & ~PENABLE;
    assign bus_access = sel_any & PENABLE;
    assign bus_done   = bus_access & PREADY;
    assign bus_wait   = bus_access & ~PREADY;
    // An ACCESS is legal only directly after SETUP or after a wait cycle
    // that belongs to the same transfer.
    assign preceded   = (state == ST_SETUP) || (state == ST_ACCESS);

    // A transfer that starts with an illegal ACCESS still captures its
    // request, so that its own wait cycles are checked for stability against
    // that request rather than against an older transfer.
    assign capture    = bus_setup | (bus_access & ~preceded);

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The FSM follows the bus even after a violation.
    always_comb begin
        state_nxt = ST_IDLE;
        if (bus_setup) begin
            state_nxt = ST_SETUP;
        end else if (bus_wait) begin
            state_nxt = ST_ACCESS;
        end
    end

    // -----------------------------------------------------------------------
    // Captured request
    // -----------------------------------------------------------------------
    logic [NUM_SEL-1:0]    cap_sel;
    logic [ADDR_WIDTH-1:0] cap_addr;
    logic                  cap_write;
    logic [2:0]            cap_prot;
    logic [DATA_WIDTH-1:0] cap_wdata;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cap_sel   <= '0;
            cap_addr  <= '0;
            cap_write <= 1'b0;
            cap_prot  <= 3'd0;
            cap_wdata <= '0;
        end else if (capture) begin
            cap_sel   <= PSEL;
            cap_addr  <= PADDR;
            cap_write <= PWRITE;
            cap_prot  <= PPROT;
            cap_wdata <= PWDATA;
        end
    end

`ifdef APB_CHK_STRB_EN
    logic [DATA_WIDTH/8-1:0] cap_strb;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cap_strb <= '0;
        end else if (capture) begin
            cap_strb <= PSTRB;
        end
    end
`endif

    logic mismatch;

    // Write data and strobes only have to hold on a write.
    always_comb begin
        mismatch = (PSEL != cap_sel) || (PADDR != cap_addr) ||
                   (PWRITE != cap_write) || (PPROT != cap_prot);
        if (cap_write && (PWDATA != cap_wdata)) begin
            mismatch = 1'b1;
        end
`ifdef APB_CHK_STRB_EN
        if (cap_write && (PSTRB != cap_strb)) begin
            mismatch = 1'b1;
        end
`endif
    end

    // -----------------------------------------------------------------------
    // Wait-state counter
    // -----------------------------------------------------------------------
    logic [7:0] wait_cnt;
    logic [7:0] wait_base;
    logic [7:0] wait_nxt;
    logic       wait_hit;

    // A wait cycle that opens a new transfer without SETUP starts counting
    // from zero. The count stops at TMO, so the timeout fires only once.
    always_comb begin
        wait_base = preceded ? wait_cnt : 8'd0;
        wait_nxt  = wait_cnt;
        wait_hit  = 1'b0;
        if (bus_setup) begin
            wait_nxt = 8'd0;
        end else if (bus_wait) begin
            wait_nxt = wait_base;
            if (wait_base < TMO) begin
                wait_nxt = wait_base + 8'd1;
                wait_hit = (wait_base == (TMO - 8'd1));
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            wait_cnt <= 8'd0;
        end else begin
            wait_cnt <= wait_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Violation detection
    // -----------------------------------------------------------------------
    logic [5:0] viol;
    logic [2:0] first_idx;

    // x & (x-1) is nonzero exactly when more than one bit of x is set.
    assign viol[0] = |(PSEL & (PSEL - NUM_SEL'(1)));
    assign viol[1] = bus_access & ~preceded;
    assign viol[2] = (state == ST_SETUP) & ~bus_access;
    assign viol[3] = bus_access & preceded & mismatch;
    assign viol[4] = wait_hit;
`ifdef APB_CHK_STRB_EN
    assign viol[5] = (bus_setup | bus_access) & ~PWRITE & (|PSTRB);
`else
    assign viol[5] = 1'b0;
`endif

    // When several classes fire together, the lowest class is reported.
    always_comb begin
        first_idx = 3'd0;
        for (int i = 5; i >= 0; i--) begin
            if (viol[i]) begin
                first_idx = 3'(i);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Reporting and counters
    // -----------------------------------------------------------------------
    logic first_free;

    // err_clr takes effect before a violation in the same cycle is recorded,
    // so that violation becomes the new first error.
    assign first_free = err_clr | (err_sticky == 6'd0);

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            err_sticky     <= 6'd0;
            err_pulse      <= 1'b0;
            err_first_code <= 3'd0;
            err_first_addr <= '0;
            txn_cnt        <= '0;
            slverr_cnt     <= 8'd0;
        end else begin
            err_pulse <= |viol;

            if (err_clr) begin
                err_sticky <= viol;
            end else begin
                err_sticky <= err_sticky | viol;
            end

            if ((|viol) && first_free) begin
                err_first_code <= first_idx;
                err_first_addr <= PADDR;
            end else if (err_clr) begin
                err_first_code <= 3'd0;
                err_first_addr <= '0;
            end

            if (bus_done && (txn_cnt != '1)) begin
                txn_cnt <= txn_cnt + CNT_WIDTH'(1);
            end
            if (bus_done && PSLVERR && (slverr_cnt != 8'hFF)) begin
                slverr_cnt <= slverr_cnt + 8'd1;
            end
        end
    end

    // PRDATA is never checked. PSTRB is also unused when the strobe checks
    // are left out of the build.
    logic unused_inputs;
`ifdef APB_CHK_STRB_EN
    assign unused_inputs = ^PRDATA;
`else
    assign unused_inputs = ^{PRDATA, PSTRB};
`endif

endmodule
